zclk_gen: RTL and testbench

Z80 clock generator, sitting directly upstream of the Z80 memory manager. It divides the 28 MHz system clock into the Z80 clock `zclk` at 3.5, 7 or 14 MHz. It produces the phase strobes `c0`..`c3` and the edge strobes `zpos`/`zneg` that the memory manager consumes. It freezes `zclk` low while the memory manager asserts `cpu_stall`.

---
 rtl/zclk_pkg.sv | 13 +
 rtl/zclk_gen.sv | 81 ++++++++
 tb/tb_zclk_gen.sv | 187 ++++++++++++++++++
 3 files changed

// File: rtl/zclk_pkg.sv
// Speed encodings and decode helper shared by the Z80 clock generator.
package zclk_pkg;

    localparam logic [1:0] TURBO_3M5 = 2'b00;
    localparam logic [1:0] TURBO_7M  = 2'b01;
    // 14 MHz is any code with bit 1 set; bit 0 is a don't-care.
    localparam logic [1:0] TURBO_14M = 2'b10;

    function automatic logic is_turbo14(input logic [1:0] turbo);
        return (turbo & TURBO_14M) != 2'b00;
    endfunction

endpackage

// File: rtl/zclk_gen.sv
// Z80 clock generator: divides 28 MHz into 3.5/7/14 MHz zclk with phase and
// edge strobes; stalls stretch only the low phase.
module zclk_gen
    import zclk_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] turbo,
    input  logic       cpu_stall,
    input  logic       ext_wait,
    output logic       c0,
    output logic       c1,
    output logic       c2,
    output logic       c3,
    output logic       zclk,
    output logic       zpos,
    output logic       zneg,
    output logic [1:0] turbo_act
);

    logic [1:0] r_cnt;
    logic       r_half;
    logic       r_zclk;
    logic [1:0] r_turbo_act;

    logic       w_rise;
    logic       w_fall;
    logic       w_stall;
    logic       w_zpos;
    logic       w_zneg;

    always_comb begin
        w_rise = 1'b0;
        w_fall = 1'b0;
        if (is_turbo14(r_turbo_act)) begin
            w_rise = r_cnt[0];
            w_fall = !r_cnt[0];
        end else if (r_turbo_act == TURBO_7M) begin
            w_rise = (r_cnt == 2'd3);
            w_fall = (r_cnt == 2'd1);
        end else if (r_turbo_act == TURBO_3M5) begin
            w_rise = (r_cnt == 2'd3) & r_half;
            w_fall = (r_cnt == 2'd3) & !r_half;
        end
    end

    assign w_stall = cpu_stall | ext_wait;
    // zneg must stay independent of the stall inputs: cpu_stall is derived from it.
    assign w_zneg  = !rst & r_zclk & w_fall;
    assign w_zpos  = !rst & !r_zclk & w_rise & !w_stall;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt       <= 2'd0;
            r_half      <= 1'b0;
            r_zclk      <= 1'b0;
            r_turbo_act <= turbo;
        end else begin
            r_cnt <= r_cnt + 2'd1;
            if (r_cnt == 2'd3)
                r_half <= !r_half;
            if (w_zpos)
                r_zclk <= 1'b1;
            else if (w_zneg)
                r_zclk <= 1'b0;
            // Speed only switches at a falling edge, so the old speed finishes its cycle.
            if (w_zneg)
                r_turbo_act <= turbo;
        end
    end

    assign c0        = (r_cnt == 2'd0);
    assign c1        = (r_cnt == 2'd1);
    assign c2        = (r_cnt == 2'd2);
    assign c3        = (r_cnt == 2'd3);
    assign zclk      = r_zclk;
    assign zpos      = w_zpos;
    assign zneg      = w_zneg;
    assign turbo_act = r_turbo_act;

endmodule

// File: tb/tb_zclk_gen.sv
// Directed bench for zclk_gen: speeds, stalls, speed switching and reset.
module tb_zclk_gen;

    logic       clk = 1'b0;
    logic       rst;
    logic [1:0] turbo;
    logic       cpu_stall;
    logic       ext_wait;
    logic       c0, c1, c2, c3;
    logic       zclk, zpos, zneg;
    logic [1:0] turbo_act;

    int n_tests = 0;
    int n_fail  = 0;

    zclk_gen dut (
        .clk       (clk),
        .rst       (rst),
        .turbo     (turbo),
        .cpu_stall (cpu_stall),
        .ext_wait  (ext_wait),
        .c0        (c0),
        .c1        (c1),
        .c2        (c2),
        .c3        (c3),
        .zclk      (zclk),
        .zpos      (zpos),
        .zneg      (zneg),
        .turbo_act (turbo_act)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [3:0] got, input logic [3:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    initial begin
        rst = 1'b1; turbo = 2'b10; cpu_stall = 1'b0; ext_wait = 1'b0;
        step();
        check("rst_tact_14", turbo_act, 2'b10);
        turbo = 2'b00;
        step();
        check("rst_phase", {c3, c2, c1, c0}, 4'b0001);
        check("rst_zclk", zclk, 1'b0);
        check("rst_zpos", zpos, 1'b0);
        check("rst_zneg", zneg, 1'b0);
        check("rst_tact_3m5", turbo_act, 2'b00);

        // 3.5 MHz from reset release: t counts clks since release
        rst = 1'b0; settle();
        for (int t = 0; t < 24; t++) begin
            check("p35_phase", {c3, c2, c1, c0}, 4'(1 << (t % 4)));
            check("p35_zpos", zpos, (t % 8 == 7));
            check("p35_zclk", zclk, (t >= 8) && (t % 8 < 4));
            check("p35_zneg", zneg, (t >= 8) && (t % 8 == 3));
            step();
        end

        // t=24, zclk high: request 7 MHz
        turbo = 2'b01; settle();
        step(); step(); step();
        check("sw7_zneg", zneg, 1'b1);
        check("sw7_tact_old", turbo_act, 2'b00);
        step();
        check("sw7_tact_new", turbo_act, 2'b01);
        check("sw7_zclk_lo", zclk, 1'b0);
        step(); step(); step();
        check("sw7_first_zpos", zpos, 1'b1);
        step();
        for (int t = 32; t < 40; t++) begin
            check("p7_zclk", zclk, (t % 4 < 2));
            check("p7_zpos", zpos, (t % 4 == 3));
            check("p7_zneg", zneg, (t % 4 == 1));
            step();
        end

        // t=40: ext_wait over t42..t44 kills the c3 rise at t43
        step(); step();
        ext_wait = 1'b1; settle();
        step();
        check("wait_skip_zpos", zpos, 1'b0);
        step();
        check("wait_zclk_lo", zclk, 1'b0);
        step();
        ext_wait = 1'b0; settle();
        check("wait_no_early", zpos, 1'b0);
        step(); step();
        check("wait_next_zpos", zpos, 1'b1);
        step();
        check("wait_zclk_hi", zclk, 1'b1);

        // t=48: request 14 MHz with code 11
        turbo = 2'b11; settle();
        step();
        check("sw14_zneg", zneg, 1'b1);
        check("sw14_tact_old", turbo_act, 2'b01);
        step();
        check("sw14_tact_new", turbo_act, 2'b11);
        check("sw14_zclk_lo", zclk, 1'b0);
        step();
        for (int t = 51; t < 60; t++) begin
            check("p14_zclk", zclk, (t % 2 == 0));
            check("p14_zpos", zpos, (t % 2 == 1));
            check("p14_zneg", zneg, (t % 2 == 0));
            step();
        end

        // t=60: cpu_stall in the zneg clk, held t60..t64
        cpu_stall = 1'b1; settle();
        check("stall_zneg", zneg, 1'b1);
        check("stall_zclk_hi", zclk, 1'b1);
        for (int k = 0; k < 4; k++) begin
            step();
            check("stall_zpos", zpos, 1'b0);
            check("stall_zclk", zclk, 1'b0);
        end
        step();
        cpu_stall = 1'b0; settle();
        check("unstall_zpos", zpos, 1'b1);
        check("unstall_zclk", zclk, 1'b0);
        step();
        check("unstall_zclk_hi", zclk, 1'b1);
        cpu_stall = 1'b1; settle();
        check("stall_hi_zneg", zneg, 1'b1);
        step();
        check("stall_hi_fall", zclk, 1'b0);
        cpu_stall = 1'b0; settle();
        check("stall_hi_zpos", zpos, 1'b1);
        step();

        // t=68, zclk high: switch 14 MHz -> 3.5 MHz
        check("sw35_zneg", zneg, 1'b1);
        turbo = 2'b00; settle();
        check("sw35_tact_old", turbo_act, 2'b11);
        step();
        check("sw35_tact_new", turbo_act, 2'b00);
        check("sw35_zclk_lo", zclk, 1'b0);
        step(); step();
        check("sw35_zpos", zpos, 1'b1);
        for (int k = 0; k < 4; k++) begin
            step();
            check("sw35_high", zclk, 1'b1);
        end
        check("sw35_zneg_end", zneg, 1'b1);
        step();
        check("sw35_fall", zclk, 1'b0);
        step(); step(); step();
        check("p35b_zpos", zpos, 1'b1);
        step();
        check("p35b_zclk", zclk, 1'b1);
        step(); step(); step();

        // t=83: zclk high in a fall slot; reset suppresses zneg
        rst = 1'b1; settle();
        check("rstmid_zneg", zneg, 1'b0);
        check("rstmid_zpos", zpos, 1'b0);
        check("rstmid_zclk_reg", zclk, 1'b1);
        step();
        check("rstmid_zclk", zclk, 1'b0);
        check("rstmid_phase", {c3, c2, c1, c0}, 4'b0001);
        check("rstmid_tact", turbo_act, 2'b00);
        rst = 1'b0; settle();
        for (int r = 0; r < 9; r++) begin
            check("rel_zpos", zpos, (r == 7));
            check("rel_zclk", zclk, (r == 8));
            step();
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
